// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_e;

  // Width of the latency down-counter: holds values 0..MEM_LATENCY-1 with headroom.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and load/store, with the anti-starvation
// counter that forces a fetch grant after a run of data-side grants.
module mem_arb_prio #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic                dm_valid,
  input  logic                accept_en,
  output logic                grant_if,
  output logic                grant_dm,
  output logic [STARVE_W-1:0] starve
);

  logic force_if;

  assign force_if = (starve == STARVE_W'(STARVE_LIMIT));

  // Data side wins by default; fetch wins when alone or when it has waited too long.
  always_comb begin
    grant_dm = accept_en && dm_valid && !(if_valid && force_if);
    grant_if = accept_en && if_valid && !grant_dm;
  end

  // Count consecutive data grants that bypassed a waiting fetch; saturate at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (!if_valid || grant_if) begin
      starve <= '0;
    end else if (grant_dm && !force_if) begin
      starve <= starve + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and
// load/store. One access is outstanding at a time; a new access may be
// issued in the same cycle the previous response returns.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // fetch side
  input  logic                    if_req_valid,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_req_ready,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // load/store side
  input  logic                    dm_req_valid,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic                    dm_req_ready,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  // memory macro side
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned CNT_W = cnt_width(MEM_LATENCY);

  arb_state_e       state;
  arb_owner_e       owner;
  logic             owner_we;
  logic [CNT_W-1:0] cnt;

  logic accept_en;
  logic rsp_p;
  logic grant_if;
  logic grant_dm;

  // The last WAIT cycle is both the response cycle and an accept slot.
  // Grants are suppressed while reset is held so every output reads 0.
  assign rsp_p     = (state == WAIT) && (cnt == '0);
  assign accept_en = !rst && ((state == IDLE) || rsp_p);

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_req_valid),
    .dm_valid  (dm_req_valid),
    .accept_en (accept_en),
    .grant_if  (grant_if),
    .grant_dm  (grant_dm),
    .starve    ()
  );

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;
  assign busy         = (state == WAIT);

  // Steer the winner's payload onto the memory port; idle port reads all-zero.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_dm) begin
      mem_req   = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end else if (grant_if) begin
      mem_req   = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Issue/wait sequencing: remember who owns the access and count down the latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      owner_we <= 1'b0;
      cnt      <= '0;
    end else if (grant_dm || grant_if) begin
      state    <= WAIT;
      owner    <= grant_dm ? OWN_DM : OWN_IF;
      owner_we <= grant_dm && dm_we;
      cnt      <= CNT_W'(MEM_LATENCY - 1);
    end else if (state == WAIT) begin
      if (cnt == '0) begin
        state    <= IDLE;
        owner    <= OWN_NONE;
        owner_we <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Route the returning word to the owner only; stores return a zero ack word.
  always_comb begin
    if_rvalid = rsp_p && (owner == OWN_IF);
    dm_rvalid = rsp_p && (owner == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !owner_we) ? mem_rdata : '0;
  end

  // Requesters must hold valid and payload steady until accepted.
  a_if_hold : assert property (@(posedge clk) disable iff (rst)
    (if_req_valid && !if_req_ready) |=> (if_req_valid && $stable(if_addr)));

  a_dm_hold : assert property (@(posedge clk) disable iff (rst)
    (dm_req_valid && !dm_req_ready) |=>
      (dm_req_valid && $stable(dm_we) && $stable(dm_addr) &&
       $stable(dm_wdata) && $stable(dm_be)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on a latency-2 instance and a
// latency-1 instance, plus a randomized run against a cycle-count model.
module tb_mem_arbiter;

  localparam int L     = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req_valid, if_req_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req_valid, dm_we, dm_req_ready, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        b_if_req_valid, b_if_req_ready, b_if_rvalid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_dm_req_ready, b_dm_rvalid;
  logic [31:0] b_dm_rdata;
  logic        b_mem_req, b_mem_we, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req_valid(dm_req_valid), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_req_ready(dm_req_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_addr(b_if_addr), .if_req_ready(b_if_req_ready),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req_valid(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_be(4'h0), .dm_req_ready(b_dm_req_ready), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Read-only memory contents as a pure function of the address.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory macro models: data appears exactly L cycles after the issue strobe.
  logic [31:0] qa [L];
  logic        qv [L];
  always @(posedge clk) begin
    qv[0] <= mem_req;
    qa[0] <= mem_addr;
    for (int i = 1; i < L; i++) begin
      qv[i] <= qv[i-1];
      qa[i] <= qa[i-1];
    end
  end
  assign mem_rdata = qv[L-1] ? memval(qa[L-1]) : 32'hBAD0_BAD0;

  logic [31:0] qb_a;
  logic        qb_v;
  always @(posedge clk) begin
    qb_v <= b_mem_req;
    qb_a <= b_mem_addr;
  end
  assign b_mem_rdata = qb_v ? memval(qb_a) : 32'hBAD1_BAD1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 1'b0; if_addr = 32'h0;
    dm_req_valid = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    b_if_req_valid = 1'b0; b_if_addr = 32'h0;
  endtask

  task automatic test_reset();
    logic [161:0] outs;
    clear_inputs();
    rst = 1'b1;
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    tick();
    @(negedge clk);
    outs = {if_req_ready, if_rvalid, if_rdata, dm_req_ready, dm_rvalid, dm_rdata,
            mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy};
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_hold outs got %h exp 0", outs);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    outs = {if_req_ready, if_rvalid, if_rdata, dm_req_ready, dm_rvalid, dm_rdata,
            mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy};
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_idle outs got %h exp 0", outs);
    end
    n_vec++;
    if ({b_if_req_ready, b_if_rvalid, b_mem_req, b_busy} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle_lat1 got %b exp 0000", {b_if_req_ready, b_if_rvalid, b_mem_req, b_busy});
    end
  endtask

  task automatic test_if_fetch();
    tick();
    if_req_valid = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    n_vec++;
    if ({if_req_ready, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL fetch_issue got rdy=%b req=%b we=%b addr=%h exp 1 1 0 0", if_req_ready, mem_req, mem_we, mem_addr);
    end
    tick();
    if_req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, if_rvalid, mem_req} !== 3'b100) begin
      n_err++;
      $display("FAIL fetch_wait got busy/rvalid/req=%b exp 100", {busy, if_rvalid, mem_req});
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h0050_0093}) begin
      n_err++;
      $display("FAIL fetch_resp got v=%b d=%h exp 1 00500093", if_rvalid, if_rdata);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({busy, if_rvalid, if_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL fetch_after got busy=%b v=%b d=%h exp 0 0 0", busy, if_rvalid, if_rdata);
    end
  endtask

  task automatic test_dm_priority();
    tick();
    if_req_valid = 1'b1; if_addr = 32'h40;
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(negedge clk);
    n_vec++;
    if ({dm_req_ready, if_req_ready, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_err++;
      $display("FAIL prio_dm_wins got dm=%b if=%b addr=%h exp 1 0 100", dm_req_ready, if_req_ready, mem_addr);
    end
    tick();
    dm_req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (if_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL prio_if_blocked got %b exp 0", if_req_ready);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({if_req_ready, mem_addr, dm_rvalid, dm_rdata} !== {1'b1, 32'h40, 1'b1, memval(32'h100)}) begin
      n_err++;
      $display("FAIL prio_if_accept got if=%b addr=%h dv=%b dd=%h exp 1 40 1 %h",
               if_req_ready, mem_addr, dm_rvalid, dm_rdata, memval(32'h100));
    end
    n_vec++;
    if (if_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL prio_nonowner_rvalid got %b exp 0", if_rvalid);
    end
    tick();
    if_req_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if ({if_rvalid, if_rdata, dm_rvalid} !== {1'b1, memval(32'h40), 1'b0}) begin
      n_err++;
      $display("FAIL prio_if_data got v=%b d=%h dv=%b exp 1 %h 0", if_rvalid, if_rdata, dm_rvalid, memval(32'h40));
    end
    tick(); tick();
  endtask

  task automatic test_starvation();
    bit exp_dm, exp_if;
    tick();
    if_req_valid = 1'b1; if_addr = 32'h80;
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int c = 0; c <= 10; c++) begin
      exp_dm = (c == 0) || (c == 2) || (c == 4) || (c == 6) || (c == 10);
      exp_if = (c == 8);
      @(negedge clk);
      n_vec++;
      if ({dm_req_ready, if_req_ready} !== {exp_dm, exp_if}) begin
        n_err++;
        $display("FAIL starve_grant c=%0d got dm=%b if=%b exp dm=%b if=%b", c, dm_req_ready, if_req_ready, exp_dm, exp_if);
      end
      if (c == 7 || c == 9) begin
        n_vec++;
        if (int'(dut.u_prio.starve) !== ((c == 7) ? LIMIT : 0)) begin
          n_err++;
          $display("FAIL starve_count c=%0d got %0d exp %0d", c, dut.u_prio.starve, (c == 7) ? LIMIT : 0);
        end
      end
      tick();
      if (exp_dm) dm_addr = dm_addr + 32'h4;
      if (exp_if) if_req_valid = 1'b0;
      if (c == 10) dm_req_valid = 1'b0;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_store();
    dm_req_valid = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    @(negedge clk);
    n_vec++;
    if ({dm_req_ready, mem_req, mem_we, mem_be, mem_wdata, mem_addr} !==
        {1'b1, 1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h200}) begin
      n_err++;
      $display("FAIL store_issue got rdy=%b req=%b we=%b be=%b wd=%h a=%h", dm_req_ready, mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    n_vec++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL store_ack got v=%b d=%h exp 1 0", dm_rvalid, dm_rdata);
    end
    tick(); tick();
  endtask

  task automatic test_lat1_back_to_back();
    logic [31:0] a [4];
    for (int k = 0; k < 4; k++) a[k] = 32'h10 + 32'(k * 4);
    b_if_req_valid = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k < 4) b_if_addr = a[k];
      else b_if_req_valid = 1'b0;
      @(negedge clk);
      if (k < 4) begin
        n_vec++;
        if ({b_if_req_ready, b_mem_req, b_mem_addr} !== {1'b1, 1'b1, a[k]}) begin
          n_err++;
          $display("FAIL lat1_accept k=%0d got rdy=%b req=%b a=%h exp 1 1 %h", k, b_if_req_ready, b_mem_req, b_mem_addr, a[k]);
        end
      end
      n_vec++;
      if (k >= 1 && k <= 4) begin
        if ({b_if_rvalid, b_if_rdata} !== {1'b1, memval(a[k-1])}) begin
          n_err++;
          $display("FAIL lat1_resp k=%0d got v=%b d=%h exp 1 %h", k, b_if_rvalid, b_if_rdata, memval(a[k-1]));
        end
      end else if ({b_if_rvalid, b_dm_rvalid} !== 2'b00) begin
        n_err++;
        $display("FAIL lat1_quiet k=%0d got v=%b dv=%b exp 0 0", k, b_if_rvalid, b_dm_rvalid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
    @(negedge clk);
    n_vec++;
    if (dm_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_accept got %b exp 1", dm_req_ready);
    end
    tick();
    dm_req_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, dm_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_busy got busy=%b dv=%b exp 0 0", busy, dm_rvalid);
    end
    tick();
    if_req_valid = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    n_vec++;
    if ({dm_rvalid, dm_rdata, if_req_ready, mem_addr} !== {1'b0, 32'h0, 1'b1, 32'h44}) begin
      n_err++;
      $display("FAIL rstmid_after got dv=%b dd=%h ifrdy=%b a=%h exp 0 0 1 44", dm_rvalid, dm_rdata, if_req_ready, mem_addr);
    end
    tick();
    if_req_valid = 1'b0;
    tick(); tick();
  endtask

  // Randomized traffic checked against a model that reasons only in cycle
  // numbers: when the last issue happened, who issued it, and the starve run.
  task automatic test_random(input int ncyc);
    int          last_acc;
    bit          last_v, last_if, last_st, g_if, g_dm, pg_if, pg_dm, can, rsp, e_busy;
    logic [31:0] last_a, e_ird, e_drd, e_addr, e_wd;
    logic [3:0]  e_be;
    bit          e_we;
    int          starve;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    last_acc = -100; last_v = 0; last_if = 0; last_st = 0; last_a = 32'h0;
    starve = 0; pg_if = 1; pg_dm = 1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (!if_req_valid || pg_if) begin
        if_req_valid = ($urandom_range(0, 99) < 60);
        if_addr = $urandom;
      end
      if (!dm_req_valid || pg_dm) begin
        dm_req_valid = ($urandom_range(0, 99) < 80);
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_be = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      can    = (cyc >= last_acc + L);
      g_dm   = can && dm_req_valid && !(if_req_valid && starve == LIMIT);
      g_if   = can && if_req_valid && !g_dm;
      rsp    = last_v && (cyc == last_acc + L);
      e_busy = last_v && (cyc > last_acc) && (cyc <= last_acc + L);
      e_ird  = (rsp && last_if) ? memval(last_a) : 32'h0;
      e_drd  = (rsp && !last_if && !last_st) ? memval(last_a) : 32'h0;
      e_addr = g_dm ? dm_addr : (g_if ? if_addr : 32'h0);
      e_we   = g_dm && dm_we;
      e_wd   = g_dm ? dm_wdata : 32'h0;
      e_be   = g_dm ? dm_be : 4'h0;
      n_vec++;
      if ({if_req_ready, dm_req_ready} !== {g_if, g_dm}) begin
        n_err++;
        $display("FAIL rnd_ready cyc=%0d got if=%b dm=%b exp if=%b dm=%b", cyc, if_req_ready, dm_req_ready, g_if, g_dm);
      end
      n_vec++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {g_if | g_dm, e_we, e_addr, e_wd, e_be}) begin
        n_err++;
        $display("FAIL rnd_mem cyc=%0d got %b %b %h %h %h exp %b %b %h %h %h", cyc, mem_req, mem_we, mem_addr,
                 mem_wdata, mem_be, g_if | g_dm, e_we, e_addr, e_wd, e_be);
      end
      n_vec++;
      if ({if_rvalid, if_rdata} !== {rsp && last_if, e_ird}) begin
        n_err++;
        $display("FAIL rnd_if_resp cyc=%0d got %b %h exp %b %h", cyc, if_rvalid, if_rdata, rsp && last_if, e_ird);
      end
      n_vec++;
      if ({dm_rvalid, dm_rdata} !== {rsp && !last_if, e_drd}) begin
        n_err++;
        $display("FAIL rnd_dm_resp cyc=%0d got %b %h exp %b %h", cyc, dm_rvalid, dm_rdata, rsp && !last_if, e_drd);
      end
      n_vec++;
      if (busy !== e_busy) begin
        n_err++;
        $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, busy, e_busy);
      end
      if (!if_req_valid || g_if) starve = 0;
      else if (g_dm && starve < LIMIT) starve = starve + 1;
      if (g_if || g_dm) begin
        last_acc = cyc;
        last_v   = 1;
        last_if  = g_if;
        last_st  = g_dm && dm_we;
        last_a   = e_addr;
      end
      pg_if = g_if;
      pg_dm = g_dm;
      tick();
    end
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_if_fetch();
    test_dm_priority();
    test_starvation();
    test_store();
    test_lat1_back_to_back();
    test_reset_mid_wait();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
